ttfs_tick_sequencer: RTL and testbench

- Parametrised successor to the single-core tick generator in the TTFS tinyODIN accelerator.
- Sequences the input time steps (ticks) of one inference.
- Waits on done pulses from NUM_CORES spike/neuron cores before it advances a tick.
- Supports free-run, single-step and TTFS early-stop modes, and captures the index and tick of the first output spike for classification readout by the control register block.

---
 rtl/ttfs_pkg.sv | 30 +++
 rtl/ttfs_tick_sequencer_done_join.sv | 36 +++
 rtl/ttfs_tick_sequencer.sv | 124 ++++++++++++
 tb/tb_ttfs_tick_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttfs_pkg.sv
// Shared types for the TTFS tick sequencing blocks: sequencer states,
// run modes and the mode decoder used when a run is started.
package ttfs_pkg;

    localparam int unsigned TTFS_MODE_W = 2;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_ADVANCE,
        SEQ_HOLD,
        SEQ_FINISH
    } tick_seq_state_e;

    typedef enum logic [TTFS_MODE_W-1:0] {
        TTFS_MODE_FREE  = 2'd0,
        TTFS_MODE_STEP  = 2'd1,
        TTFS_MODE_EARLY = 2'd2
    } ttfs_mode_e;

    // The reserved encoding falls back to free-run.
    function automatic ttfs_mode_e decode_mode(input logic [TTFS_MODE_W-1:0] m);
        case (m)
            2'd1:    return TTFS_MODE_STEP;
            2'd2:    return TTFS_MODE_EARLY;
            default: return TTFS_MODE_FREE;
        endcase
    endfunction

endpackage

// File: rtl/ttfs_tick_sequencer_done_join.sv
// Sticky per-core done flags; all_done_o also counts done pulses arriving
// in the current cycle so the last core does not cost an extra cycle.
module done_join #(
    parameter int unsigned NUM_CORES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [NUM_CORES-1:0] done_i,
    output logic                 all_done_o
);

    logic [NUM_CORES-1:0] flags_q;
    logic [NUM_CORES-1:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (clr_i) begin
            flags_d = '0;
        end else if (en_i) begin
            flags_d = flags_q | done_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign all_done_o = &(flags_q | done_i);

endmodule

// File: rtl/ttfs_tick_sequencer.sv
// Tick sequencer for one TTFS inference: joins per-core done pulses, steps
// the tick counter and captures the first output spike for readout.
module ttfs_tick_sequencer
    import ttfs_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned INPUT_RESO = 8,
    parameter int unsigned M          = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [TTFS_MODE_W-1:0] mode_i,
    input  logic [INPUT_RESO-1:0]  max_tick_i,
    input  logic                   step_i,
    input  logic [NUM_CORES-1:0]   core_done_i,
    input  logic                   out_spike_i,
    input  logic [M-1:0]           out_spike_idx_i,
    output logic [INPUT_RESO-1:0]  tick_o,
    output logic                   next_tick_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   first_valid_o,
    output logic [M-1:0]           first_idx_o,
    output logic [INPUT_RESO-1:0]  first_tick_o
);

    tick_seq_state_e        state_q;
    ttfs_mode_e             mode_q;
    logic [INPUT_RESO-1:0]  max_tick_q;
    logic [INPUT_RESO-1:0]  tick_q;
    logic                   first_valid_q;
    logic [M-1:0]           first_idx_q;
    logic [INPUT_RESO-1:0]  first_tick_q;

    logic all_done;
    logic join_en;
    logic join_clr;
    logic spike_take;

    assign join_en    = (state_q == SEQ_RUN);
    assign join_clr   = ((state_q == SEQ_IDLE) && start_i) || (state_q == SEQ_ADVANCE);
    assign spike_take = join_en && out_spike_i && !first_valid_q;

    done_join #(
        .NUM_CORES (NUM_CORES)
    ) u_join (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (join_clr),
        .en_i       (join_en),
        .done_i     (core_done_i),
        .all_done_o (all_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= SEQ_IDLE;
            mode_q        <= TTFS_MODE_FREE;
            max_tick_q    <= '0;
            tick_q        <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_tick_q  <= '0;
        end else begin
            if (spike_take) begin
                first_valid_q <= 1'b1;
                first_idx_q   <= out_spike_idx_i;
                first_tick_q  <= tick_q;
            end
            if (state_q == SEQ_IDLE) begin
                if (start_i) begin
                    mode_q        <= decode_mode(mode_i);
                    max_tick_q    <= max_tick_i;
                    tick_q        <= '0;
                    first_valid_q <= 1'b0;
                    first_idx_q   <= '0;
                    first_tick_q  <= '0;
                    state_q       <= SEQ_RUN;
                end
            end else if (abort_i) begin
                // Abort outranks every transition, including the tick increment.
                state_q <= SEQ_IDLE;
            end else begin
                case (state_q)
                    SEQ_RUN: begin
                        if (all_done) begin
                            if ((tick_q == max_tick_q) ||
                                ((mode_q == TTFS_MODE_EARLY) && (first_valid_q || spike_take))) begin
                                state_q <= SEQ_FINISH;
                            end else if (mode_q == TTFS_MODE_STEP) begin
                                state_q <= SEQ_HOLD;
                            end else begin
                                state_q <= SEQ_ADVANCE;
                            end
                        end
                    end
                    SEQ_ADVANCE: begin
                        tick_q  <= tick_q + 1'b1;
                        state_q <= SEQ_RUN;
                    end
                    SEQ_HOLD: begin
                        if (step_i) begin
                            state_q <= SEQ_ADVANCE;
                        end
                    end
                    default: begin
                        state_q <= SEQ_IDLE;
                    end
                endcase
            end
        end
    end

    assign tick_o        = tick_q;
    assign next_tick_o   = (state_q == SEQ_ADVANCE);
    assign busy_o        = (state_q != SEQ_IDLE);
    assign done_o        = (state_q == SEQ_FINISH);
    assign first_valid_o = first_valid_q;
    assign first_idx_o   = first_idx_q;
    assign first_tick_o  = first_tick_q;

endmodule

// File: tb/tb_ttfs_tick_sequencer.sv
// Randomised and directed checks of ttfs_tick_sequencer against a
// cycle-level behavioural model of the inference tick sequencing.
module tb_ttfs_tick_sequencer;

    localparam int unsigned NC   = 2;
    localparam int unsigned RESO = 8;
    localparam int unsigned MW   = 8;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            start_i;
    logic            abort_i;
    logic [1:0]      mode_i;
    logic [RESO-1:0] max_tick_i;
    logic            step_i;
    logic [NC-1:0]   core_done_i;
    logic            out_spike_i;
    logic [MW-1:0]   out_spike_idx_i;
    logic [RESO-1:0] tick_o;
    logic            next_tick_o;
    logic            busy_o;
    logic            done_o;
    logic            first_valid_o;
    logic [MW-1:0]   first_idx_o;
    logic [RESO-1:0] first_tick_o;

    ttfs_tick_sequencer #(
        .NUM_CORES  (NC),
        .INPUT_RESO (RESO),
        .M          (MW)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .mode_i          (mode_i),
        .max_tick_i      (max_tick_i),
        .step_i          (step_i),
        .core_done_i     (core_done_i),
        .out_spike_i     (out_spike_i),
        .out_spike_idx_i (out_spike_idx_i),
        .tick_o          (tick_o),
        .next_tick_o     (next_tick_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .first_valid_o   (first_valid_o),
        .first_idx_o     (first_idx_o),
        .first_tick_o    (first_tick_o)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;
    int n_nt  = 0;
    int n_dn  = 0;
    bit chk_en = 1'b0;

    // Model: a run is busy; within it the sequencer is either collecting
    // done pulses, pausing for a step, signalling the next tick, or ending.
    bit          m_busy, m_adv, m_hold, m_fin, m_fv;
    int          m_tick, m_max, m_mode, m_fi, m_ft;
    bit [NC-1:0] m_got;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_adv = 0; m_hold = 0; m_fin = 0; m_fv = 0;
        m_tick = 0; m_max = 0; m_mode = 0; m_fi = 0; m_ft = 0; m_got = '0;
    endtask

    task automatic model_step();
        bit collecting;
        collecting = m_busy && !m_adv && !m_hold && !m_fin;
        if (m_adv && core_done_i != '0) begin
            n_mis++;
            $display("FAIL protocol: core_done %0d during next tick at %0t", core_done_i, $time);
        end
        if (!m_busy) begin
            if (start_i) begin
                m_busy = 1;
                m_mode = (mode_i == 2'd3) ? 0 : int'(mode_i);
                m_max  = int'(max_tick_i);
                m_tick = 0; m_got = '0;
                m_fv = 0; m_fi = 0; m_ft = 0;
            end
        end else begin
            if (collecting && out_spike_i && !m_fv) begin
                m_fv = 1; m_fi = int'(out_spike_idx_i); m_ft = m_tick;
            end
            if (abort_i) begin
                m_busy = 0; m_adv = 0; m_hold = 0; m_fin = 0;
            end else if (m_fin) begin
                m_fin = 0; m_busy = 0;
            end else if (m_adv) begin
                m_adv = 0; m_tick = m_tick + 1; m_got = '0;
            end else if (m_hold) begin
                if (step_i) begin m_hold = 0; m_adv = 1; end
            end else begin
                m_got = m_got | core_done_i;
                if (&m_got) begin
                    if (m_tick == m_max || (m_mode == 2 && m_fv)) m_fin = 1;
                    else if (m_mode == 1) m_hold = 1;
                    else m_adv = 1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en && !RST) begin
            chk("tick",        int'(tick_o),        m_tick);
            chk("next_tick",   int'(next_tick_o),   int'(m_adv));
            chk("busy",        int'(busy_o),        int'(m_busy));
            chk("done",        int'(done_o),        int'(m_fin));
            chk("first_valid", int'(first_valid_o), int'(m_fv));
            chk("first_idx",   int'(first_idx_o),   m_fi);
            chk("first_tick",  int'(first_tick_o),  m_ft);
        end
        if (!RST) begin
            if (next_tick_o) n_nt++;
            if (done_o) n_dn++;
        end
    end

    task automatic clr_in();
        start_i = 0; abort_i = 0; mode_i = '0; max_tick_i = '0; step_i = 0;
        core_done_i = '0; out_spike_i = 0; out_spike_idx_i = '0;
    endtask

    task automatic cyc();
        @(negedge CLK);
        clr_in();
    endtask

    task automatic do_start(input int md, input int mx);
        cyc();
        start_i = 1; mode_i = md[1:0]; max_tick_i = mx[RESO-1:0];
        cyc();
    endtask

    task automatic join_tick();
        core_done_i = '1;
        cyc();
        cyc();
    endtask

    int s_nt, s_dn;

    initial begin
        clr_in();
        #2;
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_tick", int'(tick_o), 0);
        chk("reset_fv",   int'(first_valid_o), 0);
        @(negedge CLK);
        RST = 0;
        chk_en = 1;

        // Free-run, staggered core dones, max_tick 3.
        s_nt = n_nt; s_dn = n_dn;
        do_start(0, 3);
        for (int t = 0; t < 4; t++) begin
            core_done_i = 2'b01; cyc(); cyc();
            core_done_i = 2'b10; cyc(); cyc(); cyc();
        end
        cyc(); cyc();
        chk("free_adv_count",  n_nt - s_nt, 3);
        chk("free_done_count", n_dn - s_dn, 1);
        chk("free_last_tick",  int'(tick_o), 3);
        chk("free_idle",       int'(busy_o), 0);

        // Same-cycle join and duplicate pulses from one core.
        s_nt = n_nt;
        do_start(0, 1);
        core_done_i = 2'b11; cyc();
        chk("samecyc_adv", int'(next_tick_o), 1);
        cyc();
        core_done_i = 2'b01; cyc();
        core_done_i = 2'b01; cyc();
        chk("dup_core0_noadv", int'(next_tick_o), 0);
        core_done_i = 2'b10; cyc();
        chk("join_last_done", int'(done_o), 1);
        cyc(); cyc();
        chk("join_adv_count", n_nt - s_nt, 1);

        // Single-step, max_tick 2.
        do_start(1, 2);
        step_i = 1; cyc();
        chk("step_in_run_ignored", int'(next_tick_o), 0);
        for (int t = 0; t < 2; t++) begin
            core_done_i = '1; cyc(); cyc(); cyc();
            chk("hold_no_adv", int'(next_tick_o), 0);
            chk("hold_busy",   int'(busy_o), 1);
            step_i = 1; cyc();
            chk("step_adv", int'(next_tick_o), 1);
            cyc();
        end
        core_done_i = '1; cyc();
        chk("step_done", int'(done_o), 1);
        cyc();

        // Early-stop at tick 5.
        s_dn = n_dn;
        do_start(2, 200);
        repeat (5) join_tick();
        chk("early_tick5", int'(tick_o), 5);
        out_spike_i = 1; out_spike_idx_i = 8'h2A; cyc();
        out_spike_i = 1; out_spike_idx_i = 8'h11; cyc();
        core_done_i = '1; cyc();
        chk("early_done", int'(done_o), 1);
        cyc(); cyc();
        chk("early_idx",   int'(first_idx_o), 'h2A);
        chk("early_ftick", int'(first_tick_o), 5);
        chk("early_tick",  int'(tick_o), 5);
        chk("early_done_count", n_dn - s_dn, 1);

        // Abort mid-run at tick 4, then restart.
        s_dn = n_dn;
        do_start(0, 10);
        repeat (4) join_tick();
        out_spike_i = 1; out_spike_idx_i = 8'h33; cyc();
        core_done_i = 2'b01; abort_i = 1; cyc();
        chk("abort_idle",  int'(busy_o), 0);
        chk("abort_tick",  int'(tick_o), 4);
        chk("abort_fidx",  int'(first_idx_o), 'h33);
        cyc();
        chk("abort_no_done", n_dn - s_dn, 0);
        do_start(0, 10);
        chk("restart_tick", int'(tick_o), 0);
        chk("restart_fv",   int'(first_valid_o), 0);
        abort_i = 1; cyc(); cyc();

        // max_tick 0: single tick, no advance.
        s_nt = n_nt;
        do_start(0, 0);
        core_done_i = '1; cyc();
        chk("max0_done", int'(done_o), 1);
        cyc(); cyc();
        chk("max0_no_adv", n_nt - s_nt, 0);

        // Asynchronous reset in the middle of a next-tick cycle.
        do_start(0, 5);
        out_spike_i = 1; out_spike_idx_i = 8'h5C;
        join_tick();
        core_done_i = '1; cyc();
        chk("pre_rst_adv", int'(next_tick_o), 1);
        #1 RST = 1;
        #1;
        chk("rst_next_tick", int'(next_tick_o), 0);
        chk("rst_busy",      int'(busy_o), 0);
        chk("rst_tick",      int'(tick_o), 0);
        chk("rst_fv",        int'(first_valid_o), 0);
        chk("rst_fidx",      int'(first_idx_o), 0);
        cyc();
        RST = 0;

        // Randomised traffic checked cycle-by-cycle against the model.
        for (int c = 0; c < 6000; c++) begin
            int r;
            cyc();
            start_i = ($urandom_range(0, 5) == 0);
            abort_i = ($urandom_range(0, 299) == 0);
            mode_i  = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 15);
            max_tick_i = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom_range(1, 6));
            step_i  = ($urandom_range(0, 3) == 0);
            core_done_i = m_adv ? 2'b00 : 2'($urandom_range(0, 3));
            out_spike_i = ($urandom_range(0, 9) == 0);
            out_spike_idx_i = 8'($urandom_range(0, 255));
        end
        cyc(); cyc();
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
